// File: rtl/div_rem_sequencer.sv
// div_rem_sequencer: multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per cycle. Divide-by-zero and signed
// overflow resolve at accept time and skip the iteration entirely.
// Handshake: a request is taken on a rising edge where iStart=1, iFlush=0, the
//   unit is IDLE or DONE and the code is a divide/remainder op; oDone is a
//   one-cycle registered pulse marking oResult valid; oBusy is high while the
//   iteration or sign fix-up is running and the pipeline must stall.
// oDbgState exposes the FSM state (0 IDLE, 1 CALC, 2 FIXUP, 3 DONE).
module div_rem_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFlush,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic [1:0]       oDbgState
);

  // ALU control codes for the M-extension divide group
  localparam logic [4:0] OPDIV  = 5'b01100;
  localparam logic [4:0] OPDIVU = 5'b01101;
  localparam logic [4:0] OPREM  = 5'b01110;
  localparam logic [4:0] OPREMU = 5'b01111;

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_rem;      // partial remainder; always < |B| between iterations
  logic [WIDTH-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_op_valid;
  logic             w_is_signed;
  logic             w_is_rem;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_fast;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_fast_result;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Decode the request and precompute operand magnitudes and fast-path result
  always_comb begin
    w_op_valid  = (iControlSignal == OPDIV) || (iControlSignal == OPDIVU) ||
                  (iControlSignal == OPREM) || (iControlSignal == OPREMU);
    w_is_signed = (iControlSignal == OPDIV) || (iControlSignal == OPREM);
    w_is_rem    = (iControlSignal == OPREM) || (iControlSignal == OPREMU);
    w_accept    = iStart && !iFlush && w_op_valid &&
                  ((r_state == S_IDLE) || (r_state == S_DONE));
    w_div_zero  = (iB == '0);
    w_overflow  = w_is_signed && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
    w_fast      = w_div_zero || w_overflow;
    w_a_neg     = w_is_signed && iA[WIDTH-1];
    w_b_neg     = w_is_signed && iB[WIDTH-1];
    w_a_mag     = w_a_neg ? -iA : iA;
    w_b_mag     = w_b_neg ? -iB : iB;
    if (w_div_zero) begin
      w_fast_result = w_is_rem ? iA : '1;
    end else begin
      w_fast_result = w_is_rem ? '0 : iA;
    end
  end

  // One restoring step: the sign bit of the WIDTH+1 bit difference decides restore
  always_comb begin
    w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    w_diff      = w_shift_rem - {1'b0, r_div};
    w_q_fix     = r_q_neg ? -r_quo : r_quo;
    w_r_fix     = r_r_neg ? -r_rem : r_rem;
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == '0) w_state_next = S_FIXUP;
      end
      S_FIXUP: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
        else          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (iFlush) w_state_next = S_IDLE;
  end

  // Datapath: latch on accept, iterate in CALC, sign-correct and publish in FIXUP
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_is_rem <= w_is_rem;
        r_q_neg  <= w_a_neg ^ w_b_neg;
        r_r_neg  <= w_a_neg;
        r_div    <= w_b_mag;
        r_rem    <= '0;
        r_quo    <= w_a_mag;
        r_cnt    <= CNT_W'(WIDTH - 1);
        if (w_fast) r_result <= w_fast_result;
      end else if (r_state == S_CALC) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift_rem[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end else if ((r_state == S_FIXUP) && !iFlush) begin
        r_result <= r_is_rem ? w_r_fix : w_q_fix;
      end
    end
  end

  // Outputs
  always_comb begin
    oBusy     = (r_state == S_CALC) || (r_state == S_FIXUP);
    oDone     = r_done;
    oResult   = r_result;
    oDbgState = r_state;
  end

endmodule
